// File: rtl/vga_fb_arbiter_if.sv
// Purpose: draw-request handshake plus single-port framebuffer RAM bus.
// Latency: none, wiring only; RAM read data arrives one cycle after mem_addr.
// Backpressure: draw_valid/draw_ready handshake, a push happens when both are high.
interface vga_fb_arbiter_if #(
    parameter int AW = 17,
    parameter int DW = 8
);
    logic          draw_valid;
    logic [AW-1:0] draw_addr;
    logic [DW-1:0] draw_data;
    logic          draw_ready;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;

    // master: the environment side (drawing engine and the RAM itself)
    modport master (
        output draw_valid, draw_addr, draw_data, mem_rdata,
        input  draw_ready, mem_addr, mem_wdata, mem_we
    );

    // slave: the arbiter
    modport slave (
        input  draw_valid, draw_addr, draw_data, mem_rdata,
        output draw_ready, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Purpose: shares one single-port framebuffer RAM between VGA scan-out fetches and queued draw writes.
// Latency: fetch data reaches pix_data two cycles after its slot; a queued write can reach RAM the cycle after its push.
// Backpressure: draw_ready drops while the 4-entry write FIFO is full; scan-out fetches always win the RAM.

// Small synchronous FIFO; the caller guarantees no push when full and no pop when empty.
module vga_fb_wr_fifo #(
    parameter int W          = 25,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [W-1:0]        push_dat,
    input  logic                pop,
    output logic [W-1:0]        head_dat,
    output logic [DEPTH_LOG2:0] level
);
    logic [W-1:0]          mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    // entry storage, no reset needed since level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // pointers wrap naturally; push and pop together leave the level unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module vga_fb_arbiter #(
    parameter int FB_W = 320,
    parameter int FB_H = 240,
    parameter int DW   = 8,
    parameter int AW   = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic                 video_on,
    vga_fb_arbiter_if.slave      bus,
    output logic [DW-1:0]        pix_data,
    output logic [2:0]           fifo_level,
    output logic                 draw_err
);
    localparam int FB_SIZE = FB_W * FB_H;

    logic [10:0]   tx_sum;
    logic [10:0]   tx_wrap;
    logic [9:0]    tx;
    logic [9:0]    ty;
    logic          fetch;
    logic [AW-1:0] fetch_addr;
    logic          fetch_d;
    logic [DW-1:0] pix_reg;
    logic          push;
    logic          pop;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          head_ok;

    // look two pixels ahead so RAM latency plus the pixel register land on time;
    // the last two columns of a line already aim at the next line
    always_comb begin
        tx_sum  = {1'b0, x} + 11'd2;
        tx_wrap = (tx_sum >= 11'd800) ? (tx_sum - 11'd800) : tx_sum;
        tx      = tx_wrap[9:0];
        if (x < 10'd798) begin
            ty = y;
        end else if (y >= 10'd524) begin
            ty = '0;
        end else begin
            ty = y + 10'd1;
        end
        fetch      = ~tx[0] && (tx < 10'd640) && (ty < 10'd480);
        fetch_addr = AW'(ty[9:1]) * AW'(FB_W) + AW'(tx[9:1]);
    end

    // one stored pixel covers two screen columns, so one fetch per even tx is enough
    assign push    = bus.draw_valid && (fifo_level < 3'd4);
    assign pop     = !reset && !fetch && (fifo_level != 3'd0);
    assign head_ok = head_addr < AW'(FB_SIZE);

    vga_fb_wr_fifo #(
        .W          (AW + DW),
        .DEPTH_LOG2 (2)
    ) u_wr_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat ({bus.draw_addr, bus.draw_data}),
        .pop      (pop),
        .head_dat ({head_addr, head_data}),
        .level    (fifo_level)
    );

    // ready reflects only the registered level, never a same-cycle pop
    assign bus.draw_ready = reset || (fifo_level < 3'd4);

    // RAM port mux: fetch address has priority, then the FIFO head, else park at zero
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (fetch) begin
            bus.mem_addr = fetch_addr;
        end else if (pop && head_ok) begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = head_addr;
            bus.mem_wdata = head_data;
        end
    end

    // capture RAM data one cycle after each fetch slot
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_d <= 1'b0;
            pix_reg <= '0;
        end else begin
            fetch_d <= fetch;
            if (fetch_d) begin
                pix_reg <= bus.mem_rdata;
            end
        end
    end

    // out-of-range writes are dropped but remembered until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            draw_err <= 1'b0;
        end else if (pop && !head_ok) begin
            draw_err <= 1'b1;
        end
    end

    assign pix_data = video_on ? pix_reg : '0;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
    logic        clk;
    logic        reset;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic [7:0]  pix_data;
    logic [2:0]  fifo_level;
    logic        draw_err;
    logic        pl_we;
    logic [16:0] pl_addr;
    logic [7:0]  pl_dat;
    logic [7:0]  ram [0:131071];
    int          checks;
    int          errors;

    vga_fb_arbiter_if #(.AW(17), .DW(8)) bus ();

    vga_fb_arbiter #(.FB_W(320), .FB_H(240), .DW(8), .AW(17)) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .video_on   (video_on),
        .bus        (bus),
        .pix_data   (pix_data),
        .fifo_level (fifo_level),
        .draw_err   (draw_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port RAM model with one-cycle read latency and a preload port
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        else if (pl_we) ram[pl_addr] <= pl_dat;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic cyc(input logic [9:0] xi, input logic [9:0] yi, input logic von, input logic rst,
                       input logic dv, input logic [16:0] da, input logic [7:0] dd);
        @(negedge clk);
        x = xi; y = yi; video_on = von; reset = rst;
        bus.draw_valid = dv; bus.draw_addr = da; bus.draw_data = dd;
        #1;
    endtask

    task automatic preload(input logic [16:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_dat = d;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    task automatic test_reset;
        cyc(10'd700, 10'd0, 1'b1, 1'b1, 1'b0, 17'd0, 8'd0);
        preload(17'd0, 8'h5A);
        preload(17'd1, 8'h3C);
        preload(17'd2, 8'h77);
        preload(17'd3, 8'h99);
        cyc(10'd700, 10'd0, 1'b1, 1'b1, 1'b0, 17'd0, 8'd0);
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", bus.mem_we); end
        checks++; if (bus.draw_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.draw_ready); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
        checks++; if (draw_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", draw_err); end
        checks++; if (pix_data !== 8'h00) begin errors++; $display("FAIL rst_pix got %0h exp 0", pix_data); end
    endtask

    task automatic test_prefetch;
        cyc(10'd798, 10'd479, 1'b0, 1'b0, 1'b0, 17'd0, 8'd0);
        checks++; if ({bus.mem_we, bus.mem_addr} !== 18'd0) begin errors++; $display("FAIL no_fetch_479 got we=%b addr=%0d exp 0/0", bus.mem_we, bus.mem_addr); end
        cyc(10'd798, 10'd524, 1'b0, 1'b0, 1'b0, 17'd0, 8'd0);
        checks++; if ({bus.mem_we, bus.mem_addr} !== 18'd0) begin errors++; $display("FAIL prefetch_524 got we=%b addr=%0d exp 0/0", bus.mem_we, bus.mem_addr); end
        cyc(10'd798, 10'd0, 1'b0, 1'b0, 1'b0, 17'd0, 8'd0);
        checks++; if ({bus.mem_we, bus.mem_addr} !== 18'd0) begin errors++; $display("FAIL prefetch_0 got we=%b addr=%0d exp 0/0", bus.mem_we, bus.mem_addr); end
        cyc(10'd799, 10'd0, 1'b0, 1'b0, 1'b0, 17'd0, 8'd0);
        checks++; if (pix_data !== 8'h00) begin errors++; $display("FAIL blank_pix got %0h exp 0", pix_data); end
        cyc(10'd0, 10'd1, 1'b1, 1'b0, 1'b0, 17'd0, 8'd0);
        checks++; if (pix_data !== 8'h5A) begin errors++; $display("FAIL pix_x0 got %0h exp 5a", pix_data); end
        checks++; if (bus.mem_addr !== 17'd1) begin errors++; $display("FAIL fetch_x0 got %0d exp 1", bus.mem_addr); end
        cyc(10'd1, 10'd1, 1'b1, 1'b0, 1'b0, 17'd0, 8'd0);
        checks++; if (pix_data !== 8'h5A) begin errors++; $display("FAIL pix_x1 got %0h exp 5a", pix_data); end
        cyc(10'd2, 10'd1, 1'b1, 1'b0, 1'b0, 17'd0, 8'd0);
        checks++; if (pix_data !== 8'h3C) begin errors++; $display("FAIL pix_x2 got %0h exp 3c", pix_data); end
    endtask

    task automatic test_fetch_addr;
        cyc(10'd100, 10'd10, 1'b1, 1'b0, 1'b0, 17'd0, 8'd0);
        checks++; if ({bus.mem_we, bus.mem_addr} !== {1'b0, 17'd1651}) begin errors++; $display("FAIL fetch_1651 got we=%b addr=%0d exp 0/1651", bus.mem_we, bus.mem_addr); end
    endtask

    task automatic test_write_priority;
        cyc(10'd101, 10'd10, 1'b1, 1'b0, 1'b1, 17'd1000, 8'hAB);
        checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 26'd0) begin errors++; $display("FAIL idle_bypass got we=%b addr=%0d dat=%0h exp 0/0/0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        cyc(10'd102, 10'd10, 1'b1, 1'b0, 1'b0, 17'd0, 8'd0);
        checks++; if ({bus.mem_we, bus.mem_addr} !== {1'b0, 17'd1652}) begin errors++; $display("FAIL prio_fetch got we=%b addr=%0d exp 0/1652", bus.mem_we, bus.mem_addr); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL prio_level got %0d exp 1", fifo_level); end
        cyc(10'd103, 10'd10, 1'b1, 1'b0, 1'b0, 17'd0, 8'd0);
        checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 17'd1000, 8'hAB}) begin errors++; $display("FAIL prio_write got we=%b addr=%0d dat=%0h exp 1/1000/ab", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        cyc(10'd104, 10'd10, 1'b1, 1'b0, 1'b0, 17'd0, 8'd0);
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL prio_drain got %0d exp 0", fifo_level); end
        checks++; if (ram[1000] !== 8'hAB) begin errors++; $display("FAIL prio_ram got %0h exp ab", ram[1000]); end
    endtask

    task automatic test_back_to_back;
        logic [24:0] exp_q [$];
        logic [24:0] hd;
        int n;
        int wr;
        logic dv;
        n = 0; wr = 0;
        for (int i = 0; i < 40; i++) begin
            dv = (i < 20);
            cyc(10'(i), 10'd20, 1'b1, 1'b0, dv, 17'(2000 + n), 8'(n + 1));
            if (i == 7) begin
                checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_full got %0d exp 4", fifo_level); end
                checks++; if (bus.draw_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got %b exp 0", bus.draw_ready); end
            end
            if (bus.mem_we) begin
                checks++; if (i % 2 != 1) begin errors++; $display("FAIL b2b_slot write at x=%0d exp odd x", i); end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra got addr=%0d exp none", bus.mem_addr);
                end else begin
                    hd = exp_q.pop_front();
                    wr++;
                    if ({bus.mem_addr, bus.mem_wdata} !== hd) begin errors++; $display("FAIL b2b_order got %0h exp %0h", {bus.mem_addr, bus.mem_wdata}, hd); end
                end
            end else if (i % 2 == 0) begin
                checks++; if (bus.mem_addr !== 17'(3200 + (i + 2) / 2)) begin errors++; $display("FAIL b2b_fetch got %0d exp %0d", bus.mem_addr, 3200 + (i + 2) / 2); end
            end
            if (dv && bus.draw_ready) begin
                exp_q.push_back({17'(2000 + n), 8'(n + 1)});
                n++;
            end
        end
        checks++; if (n != 13) begin errors++; $display("FAIL b2b_accepted got %0d exp 13", n); end
        checks++; if (wr != 13) begin errors++; $display("FAIL b2b_written got %0d exp 13", wr); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", fifo_level); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) cyc(10'(i), 10'd0, 1'b1, 1'b0, 1'b1, 17'(500 + i), 8'(i + 8'h40));
        cyc(10'd5, 10'd0, 1'b1, 1'b1, 1'b0, 17'd0, 8'd0);
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mid_queued got %0d exp 3", fifo_level); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we got %b exp 0", bus.mem_we); end
        checks++; if (bus.draw_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", bus.draw_ready); end
        cyc(10'd6, 10'd0, 1'b1, 1'b0, 1'b0, 17'd0, 8'd0);
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", fifo_level); end
        checks++; if (draw_err !== 1'b0) begin errors++; $display("FAIL mid_err got %b exp 0", draw_err); end
        checks++; if (bus.draw_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", bus.draw_ready); end
        checks++; if (pix_data !== 8'h00) begin errors++; $display("FAIL mid_pix got %0h exp 0", pix_data); end
        for (int i = 7; i < 13; i++) begin
            cyc(10'(i), 10'd0, 1'b1, 1'b0, 1'b0, 17'd0, 8'd0);
            checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL mid_stale_write at x=%0d addr=%0d exp no write", i, bus.mem_addr); end
        end
    endtask

    task automatic test_oob;
        cyc(10'd10, 10'd500, 1'b0, 1'b0, 1'b1, 17'd76800, 8'h11);
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL oob_push_we got %b exp 0", bus.mem_we); end
        cyc(10'd11, 10'd500, 1'b0, 1'b0, 1'b0, 17'd0, 8'd0);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL oob_level got %0d exp 1", fifo_level); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL oob_pop_we got %b exp 0", bus.mem_we); end
        checks++; if (draw_err !== 1'b0) begin errors++; $display("FAIL oob_err_early got %b exp 0", draw_err); end
        cyc(10'd12, 10'd500, 1'b0, 1'b0, 1'b1, 17'd76799, 8'h22);
        checks++; if (draw_err !== 1'b1) begin errors++; $display("FAIL oob_err got %b exp 1", draw_err); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL oob_drop got %0d exp 0", fifo_level); end
        cyc(10'd13, 10'd500, 1'b0, 1'b0, 1'b0, 17'd0, 8'd0);
        checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 17'd76799, 8'h22}) begin errors++; $display("FAIL oob_last_ok got we=%b addr=%0d dat=%0h exp 1/76799/22", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        checks++; if (draw_err !== 1'b1) begin errors++; $display("FAIL oob_sticky got %b exp 1", draw_err); end
        cyc(10'd14, 10'd500, 1'b0, 1'b1, 1'b0, 17'd0, 8'd0);
        cyc(10'd15, 10'd500, 1'b0, 1'b0, 1'b0, 17'd0, 8'd0);
        checks++; if (draw_err !== 1'b0) begin errors++; $display("FAIL oob_clear got %b exp 0", draw_err); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; x = '0; y = '0; video_on = 1'b0;
        bus.draw_valid = 1'b0; bus.draw_addr = '0; bus.draw_data = '0;
        pl_we = 1'b0; pl_addr = '0; pl_dat = '0;
        test_reset;
        test_prefetch;
        test_fetch_addr;
        test_write_priority;
        test_back_to_back;
        test_reset_mid;
        test_oob;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
